// File: rtl/mod_period_meter_pkg.sv
// mod_period_meter_pkg: shared types and constants for the period meter and its helpers.
package mod_period_meter_pkg;

  // Measurement FSM: IDLE while disabled, ARM until the first rising edge, MEAS while timing.
  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } meter_state_t;

  // Averaging window is 2**AVG_LOG2 periods when averaging is compiled in.
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned AVG_N    = 1 << AVG_LOG2;

endpackage

// File: rtl/mod_sync_edge.sv
// mod_sync_edge: synchronises an asynchronous level into clk_i and flags its edges.
// rise_o/fall_o are combinational from the synchroniser output and its one-cycle delayed copy,
// so they are valid for exactly one clk_i cycle per transition.
module mod_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // Synchroniser chain plus one extra flop holding the previous synchronised level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], sig_i};
      r_level_d <= w_level;
    end
  end

  assign level_o = w_level;
  assign rise_o  = w_level & ~r_level_d;
  assign fall_o  = ~w_level & r_level_d;

endmodule

// File: rtl/mod_period_meter.sv
// mod_period_meter: measures period (rise to rise) and high time (rise to fall) of a slow
// asynchronous square wave, in clk_i cycles.
// Optional feature: define MOD_PERIOD_METER_AVG_EN to report the truncated mean of four
// consecutive periods (one valid_o per four periods, high_o from the fourth period).
module mod_period_meter
  import mod_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             w_rise_raw;
  logic             w_fall_raw;
  logic             w_level;
  logic             w_rise;
  logic             w_fall;

  meter_state_t     r_state;
  meter_state_t     w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] r_hi_cap;
  logic [CNT_W-1:0] w_hi_cap_next;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_next;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] w_high_next;
  logic             r_valid;
  logic             w_valid_next;
  logic             r_timeout;
  logic             w_timeout_next;

  // A period just closed (rise seen while measuring) / the counter saturated without a rise.
  logic             w_sample;
  logic             w_timeout_set;

  mod_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sig_i   (sig_i),
    .rise_o  (w_rise_raw),
    .fall_o  (w_fall_raw),
    .level_o (w_level)
  );

  // Edges are qualified with the settled level so a rise always sees the line high.
  assign w_rise = w_rise_raw & w_level;
  assign w_fall = w_fall_raw & ~w_level;

  // State, cycle counter and high-time capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hi_cap <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_hi_cap <= w_hi_cap_next;
    end
  end

  // FSM next state and counter. Disable beats everything; a rise beats saturation.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_hi_cap_next = r_hi_cap;
    w_sample      = 1'b0;
    w_timeout_set = 1'b0;
    if (!en_i) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = ARM;
          w_cnt_next   = '0;
        end
        ARM: begin
          if (w_rise) begin
            // First edge only opens the measurement window; no result yet.
            w_state_next = MEAS;
            w_cnt_next   = CNT_ONE;
          end else if (r_cnt == CNT_MAX) begin
            w_timeout_set = 1'b1;
            w_cnt_next    = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
        MEAS: begin
          if (w_rise) begin
            w_sample   = 1'b1;
            w_cnt_next = CNT_ONE;
          end else begin
            if (w_fall) begin
              w_hi_cap_next = r_cnt;
            end
            // Saturation never wraps: drop back to ARM and wait for a fresh edge.
            if (r_cnt == CNT_MAX) begin
              w_timeout_set = 1'b1;
              w_cnt_next    = '0;
              w_state_next  = ARM;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef MOD_PERIOD_METER_AVG_EN
  localparam int unsigned           ACC_W    = CNT_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0]   SMP_LAST = AVG_LOG2'(AVG_N - 1);
  localparam logic [AVG_LOG2-1:0]   SMP_ONE  = AVG_LOG2'(1);

  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_acc_next;
  logic [ACC_W-1:0]    w_acc_sum;
  logic [AVG_LOG2-1:0] r_smp;
  logic [AVG_LOG2-1:0] w_smp_next;
  logic                w_clear_acc;

  // A partial window is meaningless once the measurement chain is broken.
  assign w_clear_acc = ~en_i | w_timeout_set;

  // Accumulator and sample counter for the averaging window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_smp <= '0;
    end else begin
      r_acc <= w_acc_next;
      r_smp <= w_smp_next;
    end
  end
`endif

  // Result registers: capture on a closed period (or window), hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_period  <= w_period_next;
      r_high    <= w_high_next;
      r_valid   <= w_valid_next;
      r_timeout <= w_timeout_next;
    end
  end

  // Next result values; a valid strobe clears the sticky timeout.
  always_comb begin
    w_period_next  = r_period;
    w_high_next    = r_high;
    w_valid_next   = 1'b0;
    w_timeout_next = r_timeout | w_timeout_set;
`ifdef MOD_PERIOD_METER_AVG_EN
    w_acc_next = r_acc;
    w_smp_next = r_smp;
    w_acc_sum  = r_acc + {{AVG_LOG2{1'b0}}, r_cnt};
    if (w_clear_acc) begin
      w_acc_next = '0;
      w_smp_next = '0;
    end else if (w_sample) begin
      if (r_smp == SMP_LAST) begin
        w_period_next  = w_acc_sum[ACC_W-1:AVG_LOG2];
        w_high_next    = r_hi_cap;
        w_valid_next   = 1'b1;
        w_timeout_next = 1'b0;
        w_acc_next     = '0;
        w_smp_next     = '0;
      end else begin
        w_acc_next = w_acc_sum;
        w_smp_next = r_smp + SMP_ONE;
      end
    end
`else
    if (w_sample) begin
      w_period_next  = r_cnt;
      w_high_next    = r_hi_cap;
      w_valid_next   = 1'b1;
      w_timeout_next = 1'b0;
    end
`endif
  end

  assign period_o  = r_period;
  assign high_o    = r_high;
  assign valid_o   = r_valid;
  assign timeout_o = r_timeout;

endmodule
